// File: rtl/microwave_pkg.sv
// Shared types and defaults for the microwave oven cook timer.
// - timer_state_t : one-hot 5-bit timer state encoding
// - ADD_STEP_DEF  : default seconds added per panel add pulse
// - TICK_DIV_DEF  : default clk cycles per second
package microwave_pkg;

    typedef enum logic [4:0] {
        ST_EMPTY = 5'b00001,
        ST_ARMED = 5'b00010,
        ST_RUN   = 5'b00100,
        ST_HOLD  = 5'b01000,
        ST_DONE  = 5'b10000
    } timer_state_t;

    localparam int ADD_STEP_DEF = 30;
    localparam int TICK_DIV_DEF = 10;

endpackage

// File: rtl/tick_divider.sv
// Seconds prescaler for the cook timer.
// - clk, nrst : clock, async active-low reset
// - en        : count this cycle (timer running with heat)
// - sync_clr  : synchronous clear to zero, wins over en
// - tick      : one-cycle pulse on the cycle the count wraps
module tick_divider #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Tick is the wrap cycle, so the owner can act on it on the same edge.
    assign tick = en && !sync_clr && (cnt == LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            cnt <= '0;
        else if (sync_clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time counter paired with the oven controller's heat/finish handshake.
// - clk, nrst        : clock, async active-low reset
// - heat             : controller is cooking; seconds count only while high
// - load, load_val   : panel pulse, set remaining time
// - add              : panel pulse, add ADD_STEP seconds (saturating)
// - clr              : panel pulse, cancel (stop button while running)
// - finish           : registered, cooking complete (held until heat drops)
// - running          : registered, actively counting
// - remaining        : registered, seconds left
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int W        = 8,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int ADD_STEP = ADD_STEP_DEF
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         heat,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         add,
    input  logic         clr,
    output logic         finish,
    output logic         running,
    output logic [W-1:0] remaining
);

    localparam logic [W:0] ADD_W = (W+1)'(ADD_STEP);

    timer_state_t state, state_nxt;
    logic [W-1:0] rem_nxt, base;
    logic [W:0]   sum;
    logic [W-1:0] added;
    logic         tick, pre_en, pre_clr;

    // Saturating add shared by every state that accepts the add pulse.
    assign sum   = {1'b0, remaining} + ADD_W;
    assign added = sum[W] ? '1 : sum[W-1:0];

    // The prescaler only advances while really cooking; it keeps its value
    // through HOLD so a paused second is not restarted from zero.
    assign pre_en  = (state == ST_RUN) && heat && (remaining != '0);
    assign pre_clr = ((state != ST_RUN) && (state != ST_HOLD)) ||
                     ((state == ST_HOLD) && (clr || load));

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk      (clk),
        .nrst     (nrst),
        .en       (pre_en),
        .sync_clr (pre_clr),
        .tick     (tick)
    );

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        base      = add ? added : remaining;
        case (state)
            ST_EMPTY: begin
                if (clr) begin
                    state_nxt = ST_EMPTY;
                end else if (load) begin
                    if (load_val != '0) begin
                        state_nxt = ST_ARMED;
                        rem_nxt   = load_val;
                    end
                end else if (add) begin
                    state_nxt = ST_ARMED;
                    rem_nxt   = added;
                end else if (heat) begin
                    // Cooking with no time on the clock ends immediately.
                    state_nxt = ST_DONE;
                end
            end
            ST_ARMED, ST_HOLD: begin
                if (clr) begin
                    state_nxt = ST_EMPTY;
                    rem_nxt   = '0;
                end else if (load) begin
                    state_nxt = (load_val == '0) ? ST_EMPTY : ST_ARMED;
                    rem_nxt   = load_val;
                end else if (add) begin
                    rem_nxt   = added;
                end else if (heat) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Reaching zero on a tick finishes on the following edge.
                if (remaining == '0) begin
                    state_nxt = ST_DONE;
                end else if (clr) begin
                    state_nxt = ST_DONE;
                    rem_nxt   = '0;
                end else begin
                    rem_nxt = tick ? base - W'(1) : base;
                    if (!heat)
                        state_nxt = ST_HOLD;
                end
            end
            ST_DONE: begin
                // finish is held as a level until the controller drops heat.
                if (!heat)
                    state_nxt = ST_EMPTY;
            end
            default: begin
                state_nxt = ST_EMPTY;
                rem_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_EMPTY;
            remaining <= '0;
            finish    <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            finish    <= (state_nxt == ST_DONE);
            running   <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer (W=8, TICK_DIV=4, ADD_STEP=30),
// including a small oven-controller model for the door/finish race.
module tb_microwave_timer;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] rem;
        logic         fin;
        logic         run;
    } exp_t;

    typedef struct {
        logic         h;
        logic         ld;
        logic [W-1:0] lv;
        logic         ad;
        logic         cl;
        logic [W-1:0] rem;
        logic         fin;
        logic         run;
    } row_t;

    logic         clk, nrst;
    logic         heat, tb_heat, ctrl_heat, use_ctrl;
    logic         load, add, clr;
    logic [W-1:0] load_val;
    logic         finish, running;
    logic [W-1:0] remaining;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Minimal oven controller: IDLE -> COOK; door -> PAUSE; finish -> BELL.
    typedef enum logic [1:0] {C_IDLE, C_COOK, C_PAUSE, C_BELL} cst_t;
    cst_t cst;
    logic start, door, bell;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cst <= C_IDLE;
        else case (cst)
            C_IDLE:  if (start) cst <= C_COOK;
            C_COOK:  if (door) cst <= C_PAUSE; else if (finish) cst <= C_BELL;
            C_PAUSE: if (!door) cst <= C_COOK;
            default: cst <= cst;
        endcase
    end
    assign ctrl_heat = (cst == C_COOK);
    assign bell      = (cst == C_BELL);
    assign heat      = use_ctrl ? ctrl_heat : tb_heat;

    microwave_timer #(.W(W), .TICK_DIV(4), .ADD_STEP(30)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .heat      (heat),
        .load      (load),
        .load_val  (load_val),
        .add       (add),
        .clr       (clr),
        .finish    (finish),
        .running   (running),
        .remaining (remaining)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        nrst = 1'b0; tb_heat = 0; use_ctrl = 0; load = 0; load_val = '0;
        add = 0; clr = 0; start = 0; door = 0;
        repeat (3) cyc();
        exp_q.push_back('{rem: 8'd0, fin: 1'b0, run: 1'b0});
        e = exp_q.pop_front();
        checks++;
        if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
            errors++;
            $display("FAIL reset got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                     remaining, finish, running, e.rem, e.fin, e.run);
        end
        nrst = 1'b1;
        cyc();
    endtask

    task automatic test_countdown();
        row_t rows[$];
        exp_t e;
        rows.push_back('{h:0, ld:1, lv:8'd3, ad:0, cl:0, rem:8'd3, fin:0, run:0});
        for (int k = 0; k <= 12; k++)
            rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:W'(3 - k/4), fin:0, run:1});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0, fin:1, run:0});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0, fin:1, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0, fin:0, run:0});
        foreach (rows[i]) begin
            tb_heat = rows[i].h; load = rows[i].ld; load_val = rows[i].lv;
            add = rows[i].ad; clr = rows[i].cl;
            exp_q.push_back('{rem: rows[i].rem, fin: rows[i].fin, run: rows[i].run});
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
                errors++;
                $display("FAIL countdown row=%0d got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                         i, remaining, finish, running, e.rem, e.fin, e.run);
            end
        end
        load = 0;
    endtask

    task automatic test_pause_resume();
        row_t rows[$];
        exp_t e;
        logic [W-1:0] r;
        rows.push_back('{h:0, ld:1, lv:8'd5, ad:0, cl:0, rem:8'd5, fin:0, run:0});
        // t counts edges from RUN entry; heat low for t=6..25 (20 cycles).
        for (int t = 0; t <= 42; t++) begin
            r = (t < 4) ? 8'd5 : (t < 29) ? 8'd4 : (t < 33) ? 8'd3 :
                (t < 37) ? 8'd2 : (t < 41) ? 8'd1 : 8'd0;
            rows.push_back('{h: !(t >= 6 && t <= 25), ld:0, lv:8'd0, ad:0, cl:0, rem:r,
                             fin: (t == 42), run: (t <= 5) || (t >= 26 && t <= 41)});
        end
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0, fin:0, run:0});
        foreach (rows[i]) begin
            tb_heat = rows[i].h; load = rows[i].ld; load_val = rows[i].lv;
            add = rows[i].ad; clr = rows[i].cl;
            exp_q.push_back('{rem: rows[i].rem, fin: rows[i].fin, run: rows[i].run});
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
                errors++;
                $display("FAIL pause_resume row=%0d got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                         i, remaining, finish, running, e.rem, e.fin, e.run);
            end
        end
        load = 0;
    endtask

    task automatic test_saturation();
        row_t rows[$];
        exp_t e;
        rows.push_back('{h:0, ld:1, lv:8'd250, ad:0, cl:0, rem:8'd250, fin:0, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0,   ad:1, cl:0, rem:8'd255, fin:0, run:0});
        for (int k = 0; k < 4; k++)
            rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd255, fin:0, run:1});
        // add on the tick cycle: min(255+30,255)-1
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:1, cl:0, rem:8'd254, fin:0, run:1});
        // add on a non-tick cycle saturates again
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:1, cl:0, rem:8'd255, fin:0, run:1});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:1, rem:8'd0,   fin:1, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0,   fin:0, run:0});
        foreach (rows[i]) begin
            tb_heat = rows[i].h; load = rows[i].ld; load_val = rows[i].lv;
            add = rows[i].ad; clr = rows[i].cl;
            exp_q.push_back('{rem: rows[i].rem, fin: rows[i].fin, run: rows[i].run});
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
                errors++;
                $display("FAIL saturation row=%0d got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                         i, remaining, finish, running, e.rem, e.fin, e.run);
            end
        end
        load = 0; add = 0; clr = 0;
    endtask

    task automatic test_zero_time();
        row_t rows[$];
        exp_t e;
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0,  fin:1, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0,  fin:0, run:0});
        rows.push_back('{h:0, ld:1, lv:8'd0, ad:0, cl:0, rem:8'd0,  fin:0, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:1, cl:0, rem:8'd30, fin:0, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:1, rem:8'd0,  fin:0, run:0});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0,  fin:1, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0,  fin:0, run:0});
        foreach (rows[i]) begin
            tb_heat = rows[i].h; load = rows[i].ld; load_val = rows[i].lv;
            add = rows[i].ad; clr = rows[i].cl;
            exp_q.push_back('{rem: rows[i].rem, fin: rows[i].fin, run: rows[i].run});
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
                errors++;
                $display("FAIL zero_time row=%0d got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                         i, remaining, finish, running, e.rem, e.fin, e.run);
            end
        end
        load = 0; add = 0; clr = 0;
    endtask

    task automatic test_stop_cancel();
        row_t rows[$];
        exp_t e;
        // stop button in RUN
        rows.push_back('{h:0, ld:1, lv:8'd7, ad:0, cl:0, rem:8'd7, fin:0, run:0});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd7, fin:0, run:1});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:1, rem:8'd0, fin:1, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0, fin:0, run:0});
        // cancel in HOLD, then heat confirms the state is EMPTY
        rows.push_back('{h:0, ld:1, lv:8'd7, ad:0, cl:0, rem:8'd7, fin:0, run:0});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd7, fin:0, run:1});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd7, fin:0, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:1, rem:8'd0, fin:0, run:0});
        rows.push_back('{h:1, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0, fin:1, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0, ad:0, cl:0, rem:8'd0, fin:0, run:0});
        // load ignored while running
        rows.push_back('{h:0, ld:1, lv:8'd7,  ad:0, cl:0, rem:8'd7, fin:0, run:0});
        rows.push_back('{h:1, ld:0, lv:8'd0,  ad:0, cl:0, rem:8'd7, fin:0, run:1});
        rows.push_back('{h:1, ld:1, lv:8'd99, ad:0, cl:0, rem:8'd7, fin:0, run:1});
        rows.push_back('{h:1, ld:0, lv:8'd0,  ad:0, cl:0, rem:8'd7, fin:0, run:1});
        rows.push_back('{h:1, ld:0, lv:8'd0,  ad:0, cl:1, rem:8'd0, fin:1, run:0});
        rows.push_back('{h:0, ld:0, lv:8'd0,  ad:0, cl:0, rem:8'd0, fin:0, run:0});
        foreach (rows[i]) begin
            tb_heat = rows[i].h; load = rows[i].ld; load_val = rows[i].lv;
            add = rows[i].ad; clr = rows[i].cl;
            exp_q.push_back('{rem: rows[i].rem, fin: rows[i].fin, run: rows[i].run});
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
                errors++;
                $display("FAIL stop_cancel row=%0d got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                         i, remaining, finish, running, e.rem, e.fin, e.run);
            end
        end
        load = 0; clr = 0;
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        load = 1; load_val = 8'd5; cyc();
        load = 0; tb_heat = 1; repeat (3) cyc();
        nrst = 1'b0;
        #1;
        exp_q.push_back('{rem: 8'd0, fin: 1'b0, run: 1'b0});
        e = exp_q.pop_front();
        checks++;
        if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
            errors++;
            $display("FAIL reset_mid_run got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                     remaining, finish, running, e.rem, e.fin, e.run);
        end
        tb_heat = 0;
        cyc();
        nrst = 1'b1;
        exp_q.push_back('{rem: 8'd0, fin: 1'b0, run: 1'b0});
        cyc();
        e = exp_q.pop_front();
        checks++;
        if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
            errors++;
            $display("FAIL reset_release got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                     remaining, finish, running, e.rem, e.fin, e.run);
        end
    endtask

    task automatic test_door_at_finish();
        exp_t e;
        int   n;
        load = 1; load_val = 8'd1; cyc();
        load = 0;
        use_ctrl = 1; start = 1; cyc();
        start = 0;
        n = 0;
        while (!finish && n < 30) begin cyc(); n++; end
        checks++;
        if (!finish) begin
            errors++;
            $display("FAIL door_finish_wait got finish=%0b want 1 within 30 cycles", finish);
        end
        door = 1;
        cyc();
        checks++;
        if (cst !== C_PAUSE || finish !== 1'b1) begin
            errors++;
            $display("FAIL door_pause got cst=%0d fin=%0b want cst=%0d fin=1", cst, finish, C_PAUSE);
        end
        exp_q.push_back('{rem: 8'd0, fin: 1'b0, run: 1'b0});
        cyc();
        e = exp_q.pop_front();
        checks++;
        if ({remaining, finish, running} !== {e.rem, e.fin, e.run}) begin
            errors++;
            $display("FAIL door_empty got rem=%0d fin=%0b run=%0b want rem=%0d fin=%0b run=%0b",
                     remaining, finish, running, e.rem, e.fin, e.run);
        end
        door = 0;
        n = 0;
        while (!bell && n < 8) begin cyc(); n++; end
        checks++;
        if (!bell || n > 3) begin
            errors++;
            $display("FAIL door_bell got bell=%0b after %0d cycles want bell=1 within 3", bell, n);
        end
        use_ctrl = 0; tb_heat = 0;
        repeat (2) cyc();
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause_resume();
        test_saturation();
        test_zero_time();
        test_stop_cancel();
        test_reset_mid_run();
        test_door_at_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
